mux_arbiter: RTL
================

Name: mux_arbiter

Overview:
- Round-robin arbiter that shares one 4-bit output channel between two requesters, A and B.
- Drives the select of the team's 4-bit 2:1 Mux datapath: sel=1 passes B, sel=0 passes A.
- Registers the selected nibble into a one-entry output slot with a valid/ready handshake toward the downstream consumer in the PatternCounter design.
- Enforces a maximum burst length per grant so that neither requester starves the other.

Parameters:
- WIDTH, 4, data width of each requester and of the output.
- BURST_LEN, 4, maximum accepted transfers per grant while the other side is requesting. Legal range 1..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_a  input  1  requester A has data_a valid.
- data_a  input  WIDTH  requester A data.
- req_b  input  1  requester B has data_b valid.
- data_b  input  WIDTH  requester B data.
- ack_a  output  1  combinational; A's word is accepted this cycle.
- ack_b  output  1  combinational; B's word is accepted this cycle.
- sel  output  1  mux select; 1 selects B.
- out_valid  output  1  output slot holds data.
- out_data  output  WIDTH  output slot contents.
- out_ready  input  1  consumer accepts the slot this cycle.

Behaviour:
- Reset (asynchronous, active-high) sets: state=IDLE, sel=0, out_valid=0, out_data=0, burst_cnt=0, last_served=B. With last_served=B, A wins the first contention.
- States and select:
  - IDLE: sel=0, no acks.
  - GRANT_A: sel=0.
  - GRANT_B: sel=1.
- Slot handling:
  - slot_free = !out_valid || out_ready.
  - ack_a = (state==GRANT_A) && req_a && slot_free. ack_b is symmetric.
  - On any ack, at the next edge: out_data <= mux output, out_valid <= 1.
  - If out_valid && out_ready and no ack in that cycle: out_valid <= 0.
- Latency:
  - A request arriving in IDLE is granted on the next edge; its first ack can occur in the following cycle.
  - Data appears on out_data one cycle after its ack.
- IDLE transitions:
  - Only req_a: go to GRANT_A.
  - Only req_b: go to GRANT_B.
  - Both: go to the side that is not last_served.
  - burst_cnt <= 0 on any exit from IDLE.
- GRANT_A transitions (GRANT_B is symmetric):
  - req_a low: go to GRANT_B if req_b, else IDLE. last_served <= A, burst_cnt <= 0.
  - ack_a with burst_cnt==BURST_LEN-1 and req_b high: go to GRANT_B, burst_cnt <= 0, last_served <= A.
  - ack_a with burst_cnt==BURST_LEN-1 and req_b low: stay in GRANT_A, burst_cnt <= 0 (fresh burst).
  - Otherwise, ack_a increments burst_cnt.
  - A stall (req_a high, slot not free) holds state and count.
- Grant switches go directly GRANT_A <-> GRANT_B with no IDLE bubble. sel changes on the same edge as the state.
- A requester must hold its req and data stable until acked. The arbiter does not check this.
- burst_cnt is 4 bits and never wraps past BURST_LEN-1.
- Reset mid-transfer discards the slot contents, and no ack is issued while reset is high.

Decomposition:
- Shared package mux_arb_pkg holds:
  - state encodings: IDLE=2'b00, GRANT_A=2'b01, GRANT_B=2'b10;
  - the constant WIDTH_DEFAULT=4.
- One sub-module: instantiate the existing 4-bit 2:1 Mux module for data selection, with sel wired to the arbiter's sel.
- The FSM, burst counter and output slot stay in mux_arbiter.

Test Plan:
- Reset check: reset high, then release with no requests. Required: out_valid=0, sel=0, ack_a=ack_b=0 for 5 cycles.
- Single requester: req_a=1 with data_a=4'h3, out_ready=1 throughout. Required: grant one cycle after request, ack_a every cycle thereafter, out_data=3 one cycle after each ack, sel=0.
- Contention with BURST_LEN=4: req_a and req_b both held high, data_a=4'hA, data_b=4'h5, out_ready=1. Required: A is acked 4 times, then B 4 times, then A again. sel toggles on each switch; out_data sequence is A,A,A,A,5,5,5,5.
- Backpressure: in GRANT_B with the slot full, out_ready=0 for 3 cycles. Required: ack_b=0, out_data held at its last value, burst_cnt unchanged. After out_ready=1, ack_b resumes in the same cycle.
- Early drop: in GRANT_A after 2 acks, req_a falls while req_b is high. Required: the next edge moves to GRANT_B, sel=1, burst_cnt=0.
- Asynchronous reset mid-burst: assert reset between clock edges with out_valid=1. Required: out_valid, sel and state clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared encodings and defaults for the two-requester round-robin nibble arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mux_arb_pkg;

  // Arbiter FSM encodings.
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT_A = 2'b01,
    GRANT_B = 2'b10
  } arb_state_t;

  // Default requester/output data width.
  localparam int WIDTH_DEFAULT = 4;

  // Encoding of the last_served marker.
  localparam logic SIDE_A = 1'b0;
  localparam logic SIDE_B = 1'b1;

  // Terminal value of the 4-bit burst counter for a given burst length.
  function automatic logic [3:0] burst_last(input int burst_len);
    return 4'(burst_len - 1);
  endfunction

endpackage

// File: rtl/mux_arbiter_mux.sv
// 2:1 data mux for the arbiter datapath; sel=1 passes b, sel=0 passes a.
// Latency: purely combinational, zero cycles.
// Backpressure: none; pure datapath.
//
// Ports:
//   a   - input  [WIDTH-1:0] : word presented when sel=0
//   b   - input  [WIDTH-1:0] : word presented when sel=1
//   sel - input              : select
//   y   - output [WIDTH-1:0] : selected word
module mux_arbiter_mux
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = a;
    if (sel) begin
      y = b;
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Round-robin arbiter sharing one output slot between requesters A and B, with a per-grant burst cap.
// Latency: request in IDLE -> grant next edge -> first ack the cycle after; data lands in the slot one edge after its ack.
// Backpressure: acks are withheld while the slot is full and not being drained (out_valid && !out_ready).
//
// Ports:
//   clk       - input              : rising-edge clock
//   reset     - input              : asynchronous, active-high reset
//   req_a     - input              : A has data_a valid (held until acked)
//   data_a    - input  [WIDTH-1:0] : A data
//   req_b     - input              : B has data_b valid (held until acked)
//   data_b    - input  [WIDTH-1:0] : B data
//   ack_a     - output             : combinational, A's word accepted this cycle
//   ack_b     - output             : combinational, B's word accepted this cycle
//   sel       - output             : registered mux select, 1 selects B
//   out_valid - output             : output slot holds data
//   out_data  - output [WIDTH-1:0] : output slot contents
//   out_ready - input              : consumer takes the slot this cycle
module mux_arbiter
  import mux_arb_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEFAULT,
  parameter int BURST_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_a,
  input  logic [WIDTH-1:0] data_a,
  input  logic             req_b,
  input  logic [WIDTH-1:0] data_b,
  output logic             ack_a,
  output logic             ack_b,
  output logic             sel,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  // The counter is 4 bits wide, so the cap must fit in 1..15.
  if (BURST_LEN < 1 || BURST_LEN > 15) begin : g_bad_burst_len
    $error("mux_arbiter: BURST_LEN must be in 1..15");
  end

  localparam logic [3:0] BURST_LAST = burst_last(BURST_LEN);

  arb_state_t       state;
  logic [3:0]       burst_cnt;
  logic             last_served;
  logic             slot_free;
  logic             any_ack;
  logic             burst_done;
  logic [WIDTH-1:0] mux_out;

  // Slot can take a new word if empty, or if its current word leaves this cycle.
  assign slot_free  = !out_valid || out_ready;
  assign burst_done = (burst_cnt == BURST_LAST);

  // Acks are gated by reset so nothing is accepted while the slot is being cleared.
  assign ack_a   = !reset && (state == GRANT_A) && req_a && slot_free;
  assign ack_b   = !reset && (state == GRANT_B) && req_b && slot_free;
  assign any_ack = ack_a || ack_b;

  mux_arbiter_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .a   (data_a),
    .b   (data_b),
    .sel (sel),
    .y   (mux_out)
  );

  // Arbitration FSM. sel is registered alongside state so the mux flips on
  // the same edge as the grant, with no IDLE bubble on a direct handover.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sel         <= 1'b0;
      burst_cnt   <= 4'd0;
      last_served <= SIDE_B;
    end else begin
      case (state)
        IDLE: begin
          // On contention the side not served last wins.
          if (req_a && (!req_b || last_served == SIDE_B)) begin
            state     <= GRANT_A;
            sel       <= 1'b0;
            burst_cnt <= 4'd0;
          end else if (req_b) begin
            state     <= GRANT_B;
            sel       <= 1'b1;
            burst_cnt <= 4'd0;
          end
        end

        GRANT_A: begin
          if (!req_a) begin
            // A finished early: hand straight to B if waiting.
            state       <= req_b ? GRANT_B : IDLE;
            sel         <= req_b;
            last_served <= SIDE_A;
            burst_cnt   <= 4'd0;
          end else if (ack_a) begin
            if (burst_done) begin
              // Burst exhausted: yield if B waits, else start a fresh burst.
              burst_cnt <= 4'd0;
              if (req_b) begin
                state       <= GRANT_B;
                sel         <= 1'b1;
                last_served <= SIDE_A;
              end
            end else begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end
          // Stall (req_a high, slot busy): hold state and count.
        end

        GRANT_B: begin
          if (!req_b) begin
            state       <= req_a ? GRANT_A : IDLE;
            sel         <= 1'b0;
            last_served <= SIDE_B;
            burst_cnt   <= 4'd0;
          end else if (ack_b) begin
            if (burst_done) begin
              burst_cnt <= 4'd0;
              if (req_a) begin
                state       <= GRANT_A;
                sel         <= 1'b0;
                last_served <= SIDE_B;
              end
            end else begin
              burst_cnt <= burst_cnt + 4'd1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          sel       <= 1'b0;
          burst_cnt <= 4'd0;
        end
      endcase
    end
  end

  // One-entry output slot. A new ack takes priority over draining, which
  // lets the slot stream one word per cycle while the consumer is ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (any_ack) begin
      out_valid <= 1'b1;
      out_data  <= mux_out;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
